ccip_batch_transmitter: RTL and testbench
=========================================

# ccip_batch_transmitter

NIC-to-CPU transmit path of a NIC flow block. Accepts one RPC cache line per cycle tagged with a flow ID and stages it in a per-flow batch buffer held in a single-clock RAM. When a flow's batch fills, the block emits the whole batch over CCI-P channel 1 as `eREQ_WRLINE_I` writes into that flow's host TX region. It sits beside the RX polling logic under the per-NIC CCI-P wrapper.

## Interface
- `NIC_ID`, 0: NIC index, used only in simulation messages.
- `LMAX_NUM_OF_FLOWS`, 1: log2 of the maximum number of flows.
- `LMAX_CCIP_BATCH`, 2: log2 of the maximum batch size and of the per-flow host region size in lines.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-low.
- `number_of_flows`  in  LMAX_NUM_OF_FLOWS  highest valid flow index.
- `tx_base_addr`  in  t_ccip_clAddr  host TX region base (line address).
- `l_tx_batch_size`  in  LMAX_CCIP_BATCH  log2 of the batch size B.
- `start`  in  1  enables traffic.
- `initialize`  in  1  one-shot init request.
- `initialized`  out  1  init complete.
- `error`  out  1  sticky configuration or flow-ID error.
- `sRx_c1TxAlmFull`  in  1  CCI-P channel 1 almost-full.
- `sTx_c1`  out  t_if_ccip_c1_Tx  CCI-P write request.
- `ccip_tx_ready`  out  1  can accept an RPC this cycle.
- `rpc_in`  in  RpcIf  RPC payload, zero-extended to 512 bits.
- `rpc_in_valid`  in  1  payload valid.
- `rpc_flow_id_in`  in  LMAX_NUM_OF_FLOWS  destination flow.
- `pdrop_tx_flows_out`  out  1  drop pulse.

## Operation
- **Buffer RAM**
  - One `single_clock_wr_ram`: 512-bit data, address {flow, slot} of LMAX_NUM_OF_FLOWS+LMAX_CCIP_BATCH bits.
  - Registered read with 1-cycle latency; a same-cycle read of an address being written returns the old data.
- **Per-flow state**: a slot counter of LMAX_CCIP_BATCH+1 bits. B = 1 << l_tx_batch_size.
- **Init**
  - While `initialized`=0 and `initialize`=1, all slot counters clear and `initialized` rises the next cycle.
  - `initialized` stays high until reset.
- **States**: Idle and Flush.
- **Ready rule**: `ccip_tx_ready` = `initialized` & `start` & state==Idle.
- **Accept**: when `rpc_in_valid` & `ccip_tx_ready`:
  - write `rpc_in` to RAM[{flow, cnt[flow]}];
  - increment cnt[flow];
  - if cnt[flow]+1 == B, latch the flow, clear cnt[flow], and go to Flush.
- **Drop**: when `rpc_in_valid` & `start` & !`ccip_tx_ready`, the RPC is discarded.
- **Flush**
  - Issue RAM reads for slots 0..B-1 in order, one per cycle. No read is issued in a cycle where `sRx_c1TxAlmFull`=1.
  - Each read produces one `sTx_c1` write the following cycle.
  - Write header fields:
    - `req_type` = eREQ_WRLINE_I
    - `vc_sel` = eVC_VA
    - `cl_len` = eCL_LEN_1
    - `sop` = 1
    - `mdata` = 0
    - `address` = `tx_base_addr` + (flow << LMAX_CCIP_BATCH) + slot
  - Return to Idle the cycle after the last read.
- **Error** (sticky until reset); an invalid RPC is also dropped:
  - accepted RPC with `rpc_flow_id_in` > `number_of_flows`;
  - `l_tx_batch_size` > LMAX_CCIP_BATCH observed while `start`=1.
- **Start deasserted**
  - An in-progress flush completes.
  - Partial batches are retained.
  - No new RPCs are accepted.

## Timing
- **Reset values**:
  - `sTx_c1.valid` 0, `ccip_tx_ready` 0, `initialized` 0, `error` 0, `pdrop_tx_flows_out` 0;
  - state Idle, all counters 0.
  - Reset has priority over every other event, including mid-flush; a flush in progress is abandoned.
- **Accept to RAM**: accept at cycle N writes the RAM at N+1.
- **Batch completion**: the completing accept at N puts the block in Flush at N+1 (`ccip_tx_ready`=0). The first read issues at N+1 and the first `sTx_c1.valid` comes at N+2.
- **Flush throughput**: with almFull=0, B back-to-back valid writes; ready returns at N+B+1.
- **Back-pressure**: almFull inserts bubbles only; no write is lost or duplicated.
- **B=1**: every accepted RPC produces exactly one write two cycles later.
- **Output registering**: `sTx_c1.valid` is registered and high for exactly one cycle per line.

## Configuration
- `CCIP_TX_DROP_STATS_EN`
  - Defined: `pdrop_tx_flows_out` pulses high for one cycle, registered one cycle after each dropped RPC.
  - Undefined: `pdrop_tx_flows_out` is tied to 0 and drop-detection logic is removed. Drop behaviour itself is unchanged.

## Test plan
- **Init**: reset, then `initialize` pulse -> `initialized`=1 one cycle later; `ccip_tx_ready`=1 once `start`=1.
- **Batch of 4**: B=4, flow 0, payloads 0xA0..0xA3, base 0x1000 -> four writes to 0x1000..0x1003 carrying A0..A3 in order, consecutive cycles, then ready again.
- **Interleaved flows**: B=2, `number_of_flows`=1, RPCs to flows 1,0,1 -> flow 1 flushes to base+4 and base+5; flow 0 holds one pending line with no write.
- **Back-pressure and drop**: almFull=1 for 3 cycles mid-flush -> all 4 lines still emitted once; an RPC arriving during flush -> no write for it and one `pdrop_tx_flows_out` pulse.
- **Error**: `number_of_flows`=0, RPC to flow 1 -> `error`=1 (sticky), no write.
- **Reset mid-flush**: assert reset during flush -> `sTx_c1.valid`=0 next cycle and `initialized`=0.

Source files
------------

// File: rtl/ccip_batch_transmitter.sv
// ccip_batch_transmitter: gathers RPC cache lines into per-flow batches held
// in a single-clock RAM. When a flow's batch fills, the whole batch goes out
// on CCI-P channel 1 as WrLine_I writes into that flow's host TX region.
// Optional feature macro: CCIP_TX_DROP_STATS_EN. When it is defined,
// pdrop_tx_flows_out pulses once for each dropped RPC. When it is undefined,
// the output is tied to 0.
// The CCI-P c1 request appears as flattened sTx_c1_* fields.

// Single-clock RAM: registered read with one cycle of latency.
// A read of the address being written in the same cycle returns the old data.
module single_clock_wr_ram #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

module ccip_batch_transmitter #(
  parameter int NIC_ID            = 0,
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LMAX_CCIP_BATCH   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  logic [41:0]                  tx_base_addr,
  input  logic [LMAX_CCIP_BATCH-1:0]   l_tx_batch_size,
  input  logic                         start,
  input  logic                         initialize,
  output logic                         initialized,
  output logic                         error,
  input  logic                         sRx_c1TxAlmFull,
  output logic                         sTx_c1_valid,
  output logic [3:0]                   sTx_c1_req_type,
  output logic [1:0]                   sTx_c1_vc_sel,
  output logic [1:0]                   sTx_c1_cl_len,
  output logic                         sTx_c1_sop,
  output logic [15:0]                  sTx_c1_mdata,
  output logic [41:0]                  sTx_c1_address,
  output logic [511:0]                 sTx_c1_data,
  output logic                         ccip_tx_ready,
  input  logic [511:0]                 rpc_in,
  input  logic                         rpc_in_valid,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_in,
  output logic                         pdrop_tx_flows_out
);
  localparam int LF = LMAX_NUM_OF_FLOWS;
  localparam int LB = LMAX_CCIP_BATCH;
  localparam int NF = 1 << LF;
  localparam int CW = LB + 1;
  localparam int AW = LF + LB;
  localparam logic [LB-1:0] LB_MAX = LB'(LB);

  // CCI-P encodings: eREQ_WRLINE_I, eVC_VA, eCL_LEN_1.
  localparam logic [3:0] REQ_WRLINE_I = 4'h0;
  localparam logic [1:0] VC_VA        = 2'b00;
  localparam logic [1:0] CL_LEN_1     = 2'b00;

  // A negative NIC index is meaningless; NIC_ID only tags simulation messages.
  if (NIC_ID < 0) begin : g_bad_nic_id
  end

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t               state_q, state_d;
  logic [NF-1:0][CW-1:0] cnt_q;
  logic                 initialized_q;
  logic                 error_q;
  logic [LF-1:0]        flush_flow_q;
  logic [CW-1:0]        rd_slot_q;
  logic                 out_vld_q;
  logic [41:0]          out_addr_q;
  logic [511:0]         ram_rdata;

  logic                 ready;
  logic                 flow_ok;
  logic                 accept;
  logic                 bad_flow;
  logic [CW-1:0]        batch_b;
  logic [CW-1:0]        cnt_cur;
  logic [CW-1:0]        cnt_inc;
  logic                 batch_done;
  logic                 rd_en;
  logic                 rd_last;
  logic                 cfg_err;

  // Accept / completion / flush-read decode.
  always_comb begin
    ready      = initialized_q & start & (state_q == ST_IDLE);
    flow_ok    = (rpc_flow_id_in <= number_of_flows);
    accept     = rpc_in_valid & ready & flow_ok;
    bad_flow   = rpc_in_valid & ready & ~flow_ok;
    batch_b    = CW'(1) << l_tx_batch_size;
    cnt_cur    = cnt_q[rpc_flow_id_in];
    cnt_inc    = cnt_cur + CW'(1);
    batch_done = accept & (cnt_inc == batch_b);
    rd_en      = (state_q == ST_FLUSH) & ~sRx_c1TxAlmFull;
    rd_last    = (rd_slot_q == (batch_b - CW'(1)));
    cfg_err    = start & (l_tx_batch_size > LB_MAX);
  end

  // Next-state logic: a filled batch starts a flush; the last read ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (batch_done) state_d = ST_FLUSH;
      ST_FLUSH: if (rd_en && rd_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control state: FSM, per-flow slot counters, init/error flags, flush cursor.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      initialized_q <= 1'b0;
      error_q       <= 1'b0;
      flush_flow_q  <= '0;
      rd_slot_q     <= '0;
      out_vld_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!initialized_q && initialize) begin
        cnt_q         <= '0;
        initialized_q <= 1'b1;
      end else if (accept) begin
        cnt_q[rpc_flow_id_in] <= batch_done ? '0 : cnt_inc;
      end
      if (batch_done) begin
        flush_flow_q <= rpc_flow_id_in;
        rd_slot_q    <= '0;
      end else if (rd_en) begin
        rd_slot_q <= rd_slot_q + CW'(1);
      end
      if (bad_flow || cfg_err) error_q <= 1'b1;
      out_vld_q <= rd_en;
    end
  end

  // Write address travels with the RAM read so both land in the same cycle.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      out_addr_q <= tx_base_addr + {{(42-AW){1'b0}}, flush_flow_q, rd_slot_q[LB-1:0]};
    end
  end

  single_clock_wr_ram #(
    .DATA_W (512),
    .ADDR_W (AW)
  ) u_batch_ram (
    .clk   (clk),
    .we    (accept),
    .waddr ({rpc_flow_id_in, cnt_cur[LB-1:0]}),
    .wdata (rpc_in),
    .re    (rd_en),
    .raddr ({flush_flow_q, rd_slot_q[LB-1:0]}),
    .rdata (ram_rdata)
  );

  assign initialized     = initialized_q;
  assign error           = error_q;
  assign ccip_tx_ready   = ready;
  assign sTx_c1_valid    = out_vld_q;
  assign sTx_c1_req_type = REQ_WRLINE_I;
  assign sTx_c1_vc_sel   = VC_VA;
  assign sTx_c1_cl_len   = CL_LEN_1;
  assign sTx_c1_sop      = 1'b1;
  assign sTx_c1_mdata    = 16'h0000;
  assign sTx_c1_address  = out_addr_q;
  assign sTx_c1_data     = ram_rdata;

`ifdef CCIP_TX_DROP_STATS_EN
  logic drop;
  logic pdrop_q;

  assign drop = (rpc_in_valid & start & ~ready) | bad_flow;

  // One-cycle drop pulse, registered after the dropped RPC.
  always_ff @(posedge clk) begin
    if (!reset) pdrop_q <= 1'b0;
    else        pdrop_q <= drop;
  end

  assign pdrop_tx_flows_out = pdrop_q;
`else
  assign pdrop_tx_flows_out = 1'b0;
`endif
endmodule

// File: tb/tb_ccip_batch_transmitter.sv
// Directed testbench for ccip_batch_transmitter (LMAX_NUM_OF_FLOWS=1, LMAX_CCIP_BATCH=2).
module tb_ccip_batch_transmitter;
  localparam int LF = 1;
  localparam int LB = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [LF-1:0] number_of_flows;
  logic [41:0]   tx_base_addr;
  logic [LB-1:0] l_tx_batch_size;
  logic          start, initialize, initialized, error, sRx_c1TxAlmFull;
  logic          sTx_c1_valid, sTx_c1_sop;
  logic [3:0]    sTx_c1_req_type;
  logic [1:0]    sTx_c1_vc_sel, sTx_c1_cl_len;
  logic [15:0]   sTx_c1_mdata;
  logic [41:0]   sTx_c1_address;
  logic [511:0]  sTx_c1_data;
  logic          ccip_tx_ready;
  logic [511:0]  rpc_in;
  logic          rpc_in_valid;
  logic [LF-1:0] rpc_flow_id_in;
  logic          pdrop_tx_flows_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [41:0]  wr_addr[$];
  logic [511:0] wr_data[$];
  logic [24:0]  wr_hdr[$];
  int           wr_cyc[$];
  int           pdrop_cnt = 0;

  ccip_batch_transmitter #(
    .NIC_ID            (0),
    .LMAX_NUM_OF_FLOWS (LF),
    .LMAX_CCIP_BATCH   (LB)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .number_of_flows    (number_of_flows),
    .tx_base_addr       (tx_base_addr),
    .l_tx_batch_size    (l_tx_batch_size),
    .start              (start),
    .initialize         (initialize),
    .initialized        (initialized),
    .error              (error),
    .sRx_c1TxAlmFull    (sRx_c1TxAlmFull),
    .sTx_c1_valid       (sTx_c1_valid),
    .sTx_c1_req_type    (sTx_c1_req_type),
    .sTx_c1_vc_sel      (sTx_c1_vc_sel),
    .sTx_c1_cl_len      (sTx_c1_cl_len),
    .sTx_c1_sop         (sTx_c1_sop),
    .sTx_c1_mdata       (sTx_c1_mdata),
    .sTx_c1_address     (sTx_c1_address),
    .sTx_c1_data        (sTx_c1_data),
    .ccip_tx_ready      (ccip_tx_ready),
    .rpc_in             (rpc_in),
    .rpc_in_valid       (rpc_in_valid),
    .rpc_flow_id_in     (rpc_flow_id_in),
    .pdrop_tx_flows_out (pdrop_tx_flows_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every emitted write and drop pulse, sampled on the falling edge.
  always @(negedge clk) begin
    if (sTx_c1_valid === 1'b1) begin
      wr_addr.push_back(sTx_c1_address);
      wr_data.push_back(sTx_c1_data);
      wr_hdr.push_back({sTx_c1_req_type, sTx_c1_vc_sel, sTx_c1_cl_len, sTx_c1_sop, sTx_c1_mdata});
      wr_cyc.push_back(cyc);
    end
    if (pdrop_tx_flows_out === 1'b1) pdrop_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [LF-1:0] f, input logic [511:0] d);
    rpc_flow_id_in = f;
    rpc_in         = d;
    rpc_in_valid   = 1'b1;
    step();
    rpc_in_valid   = 1'b0;
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_hdr.delete();
    wr_cyc.delete();
    pdrop_cnt = 0;
  endtask

  // Steps until ready rises; reports the cycle it was seen and whether it came in time.
  task automatic wait_ready(output int at_cyc, output bit ok);
    int k;
    k = 0;
    while (ccip_tx_ready !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    ok     = (ccip_tx_ready === 1'b1);
    at_cyc = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; initialize = 1'b0; sRx_c1TxAlmFull = 1'b0;
    rpc_in_valid = 1'b0; rpc_in = '0; rpc_flow_id_in = '0;
    number_of_flows = 1'b1; tx_base_addr = 42'h1000; l_tx_batch_size = 2'd2;
    repeat (3) step();
    n_cmp++; if (sTx_c1_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", sTx_c1_valid); end
    n_cmp++; if (ccip_tx_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ccip_tx_ready); end
    n_cmp++; if (initialized !== 1'b0) begin n_bad++; $display("FAIL reset_init: got %b want 0", initialized); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
    n_cmp++; if (pdrop_tx_flows_out !== 1'b0) begin n_bad++; $display("FAIL reset_pdrop: got %b want 0", pdrop_tx_flows_out); end
    reset = 1'b1;
    start = 1'b0;
    step();
    n_cmp++; if (initialized !== 1'b0) begin n_bad++; $display("FAIL noinit_init: got %b want 0", initialized); end
  endtask

  task automatic test_init();
    initialize = 1'b1;
    #1;
    n_cmp++; if (initialized !== 1'b0) begin n_bad++; $display("FAIL init_before_edge: got %b want 0", initialized); end
    step();
    initialize = 1'b0;
    n_cmp++; if (initialized !== 1'b1) begin n_bad++; $display("FAIL init_after_edge: got %b want 1", initialized); end
    n_cmp++; if (ccip_tx_ready !== 1'b0) begin n_bad++; $display("FAIL init_ready_nostart: got %b want 0", ccip_tx_ready); end
    start = 1'b1;
    #1;
    n_cmp++; if (ccip_tx_ready !== 1'b1) begin n_bad++; $display("FAIL init_ready_start: got %b want 1", ccip_tx_ready); end
  endtask

  task automatic test_batch4();
    int c3, rc;
    bit ok;
    l_tx_batch_size = 2'd2; tx_base_addr = 42'h1000; number_of_flows = 1'b1;
    clear_mon();
    for (int i = 0; i < 4; i++) send(1'b0, 512'hA0 + 512'(i));
    c3 = cyc;
    n_cmp++; if (ccip_tx_ready !== 1'b0) begin n_bad++; $display("FAIL b4_ready_in_flush: got %b want 0", ccip_tx_ready); end
    wait_ready(rc, ok);
    n_cmp++; if (!ok || rc != c3 + 4) begin n_bad++; $display("FAIL b4_ready_return: got cycle %0d (ok=%0d) want %0d", rc, ok, c3 + 4); end
    step();
    n_cmp++; if (wr_addr.size() != 4) begin n_bad++; $display("FAIL b4_count: got %0d want 4", wr_addr.size()); end
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      n_cmp++; if (wr_addr[i] !== 42'h1000 + 42'(i)) begin n_bad++; $display("FAIL b4_addr%0d: got %h want %h", i, wr_addr[i], 42'h1000 + 42'(i)); end
      n_cmp++; if (wr_data[i] !== 512'hA0 + 512'(i)) begin n_bad++; $display("FAIL b4_data%0d: got %h want %h", i, wr_data[i][15:0], 16'hA0 + 16'(i)); end
      n_cmp++; if (wr_cyc[i] != c3 + 1 + i) begin n_bad++; $display("FAIL b4_cycle%0d: got %0d want %0d", i, wr_cyc[i], c3 + 1 + i); end
      n_cmp++; if (wr_hdr[i] !== 25'h0010000) begin n_bad++; $display("FAIL b4_hdr%0d: got %h want 0010000", i, wr_hdr[i]); end
    end
  endtask

  task automatic test_interleaved();
    int rc;
    bit ok;
    l_tx_batch_size = 2'd1; number_of_flows = 1'b1; tx_base_addr = 42'h2000;
    clear_mon();
    send(1'b1, 512'hB10);
    send(1'b0, 512'hB00);
    send(1'b1, 512'hB11);
    wait_ready(rc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL il_ready_timeout: got 0 want 1"); end
    repeat (2) step();
    n_cmp++; if (wr_addr.size() != 2) begin n_bad++; $display("FAIL il_count_f1: got %0d want 2", wr_addr.size()); end
    if (wr_addr.size() >= 2) begin
      n_cmp++; if (wr_addr[0] !== 42'h2004 || wr_addr[1] !== 42'h2005) begin n_bad++; $display("FAIL il_addr_f1: got %h %h want 2004 2005", wr_addr[0], wr_addr[1]); end
      n_cmp++; if (wr_data[0] !== 512'hB10 || wr_data[1] !== 512'hB11) begin n_bad++; $display("FAIL il_data_f1: got %h %h want B10 B11", wr_data[0][15:0], wr_data[1][15:0]); end
    end
    clear_mon();
    send(1'b0, 512'hB01);
    wait_ready(rc, ok);
    repeat (2) step();
    n_cmp++; if (wr_addr.size() != 2) begin n_bad++; $display("FAIL il_count_f0: got %0d want 2", wr_addr.size()); end
    if (wr_addr.size() >= 2) begin
      n_cmp++; if (wr_addr[0] !== 42'h2000 || wr_addr[1] !== 42'h2001) begin n_bad++; $display("FAIL il_addr_f0: got %h %h want 2000 2001", wr_addr[0], wr_addr[1]); end
      n_cmp++; if (wr_data[0] !== 512'hB00 || wr_data[1] !== 512'hB01) begin n_bad++; $display("FAIL il_data_f0: got %h %h want B00 B01", wr_data[0][15:0], wr_data[1][15:0]); end
    end
  endtask

  task automatic test_backpressure_drop();
    int c3, rc, exp_drop;
    bit ok;
    int exp_cyc[4];
    exp_cyc[0] = 1; exp_cyc[1] = 5; exp_cyc[2] = 6; exp_cyc[3] = 7;
`ifdef CCIP_TX_DROP_STATS_EN
    exp_drop = 1;
`else
    exp_drop = 0;
`endif
    l_tx_batch_size = 2'd2; tx_base_addr = 42'h3000;
    clear_mon();
    for (int i = 0; i < 4; i++) send(1'b0, 512'hC0 + 512'(i));
    c3 = cyc;
    step();
    sRx_c1TxAlmFull = 1'b1;
    rpc_flow_id_in = 1'b1; rpc_in = 512'hEE; rpc_in_valid = 1'b1;
    n_cmp++; if (ccip_tx_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_in_flush: got %b want 0", ccip_tx_ready); end
    step();
    rpc_in_valid = 1'b0;
    repeat (2) step();
    sRx_c1TxAlmFull = 1'b0;
    wait_ready(rc, ok);
    n_cmp++; if (!ok || rc != c3 + 7) begin n_bad++; $display("FAIL bp_ready_return: got cycle %0d (ok=%0d) want %0d", rc, ok, c3 + 7); end
    repeat (2) step();
    n_cmp++; if (wr_addr.size() != 4) begin n_bad++; $display("FAIL bp_count: got %0d want 4", wr_addr.size()); end
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      n_cmp++; if (wr_addr[i] !== 42'h3000 + 42'(i) || wr_data[i] !== 512'hC0 + 512'(i)) begin n_bad++; $display("FAIL bp_line%0d: got %h/%h want %h/%h", i, wr_addr[i], wr_data[i][15:0], 42'h3000 + 42'(i), 16'hC0 + 16'(i)); end
      n_cmp++; if (wr_cyc[i] != c3 + exp_cyc[i]) begin n_bad++; $display("FAIL bp_cycle%0d: got %0d want %0d", i, wr_cyc[i], c3 + exp_cyc[i]); end
    end
    n_cmp++; if (pdrop_cnt != exp_drop) begin n_bad++; $display("FAIL bp_pdrop: got %0d pulses want %0d", pdrop_cnt, exp_drop); end
  endtask

  task automatic test_error_and_b1();
    int c, rc;
    bit ok;
    l_tx_batch_size = 2'd0; number_of_flows = 1'b0; tx_base_addr = 42'h4000;
    clear_mon();
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL err_before: got %b want 0", error); end
    send(1'b1, 512'hDD);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", error); end
    number_of_flows = 1'b1;
    repeat (3) step();
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", error); end
    n_cmp++; if (wr_addr.size() != 0) begin n_bad++; $display("FAIL err_no_write: got %0d writes want 0", wr_addr.size()); end
    send(1'b0, 512'hF0);
    c = cyc;
    wait_ready(rc, ok);
    n_cmp++; if (!ok || rc != c + 1) begin n_bad++; $display("FAIL b1_ready_return: got cycle %0d (ok=%0d) want %0d", rc, ok, c + 1); end
    repeat (2) step();
    n_cmp++; if (wr_addr.size() != 1) begin n_bad++; $display("FAIL b1_count: got %0d want 1", wr_addr.size()); end
    if (wr_addr.size() >= 1) begin
      n_cmp++; if (wr_addr[0] !== 42'h4000 || wr_data[0] !== 512'hF0 || wr_cyc[0] != c + 1) begin n_bad++; $display("FAIL b1_write: got %h/%h@%0d want 4000/F0@%0d", wr_addr[0], wr_data[0][15:0], wr_cyc[0], c + 1); end
    end
  endtask

  task automatic test_reset_midflush();
    l_tx_batch_size = 2'd2; tx_base_addr = 42'h5000;
    clear_mon();
    for (int i = 0; i < 4; i++) send(1'b0, 512'hE0 + 512'(i));
    step();
    reset = 1'b0;
    step();
    n_cmp++; if (sTx_c1_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", sTx_c1_valid); end
    n_cmp++; if (initialized !== 1'b0) begin n_bad++; $display("FAIL rst_mid_init: got %b want 0", initialized); end
    n_cmp++; if (ccip_tx_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 0", ccip_tx_ready); end
    reset = 1'b1;
    repeat (4) step();
    n_cmp++; if (wr_addr.size() != 1) begin n_bad++; $display("FAIL rst_mid_count: got %0d writes want 1", wr_addr.size()); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL rst_error_clear: got %b want 0", error); end
    l_tx_batch_size = 2'd3;
    step();
    l_tx_batch_size = 2'd2;
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL cfg_error: got %b want 1", error); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_batch4();
    test_interleaved();
    test_backpressure_drop();
    test_error_and_b1();
    test_reset_midflush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
